fifo_write_arbiter: RTL

Round-robin arbiter that shares the single write port of the async FIFO among `NUM_REQ` write-domain requesters. Each grant is a burst: the winner streams words until it marks the last word, reaches `MAX_BURST`, or drops its request. The arbiter respects `wfull` so the FIFO never overflows. It sits entirely in the write clock domain, in front of the FIFO's `winc`/`wdata` inputs.

---
 rtl/fifo_write_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter feeding the single write port of an async FIFO.
// Each grant streams words until req_last, MAX_BURST words, or the owner withdraws.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  localparam int ID_W      = $clog2(NUM_REQ),
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                          wclk,
  input  logic                          wrst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          wfull,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [NUM_REQ-1:0]            grant,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [ID_W-1:0]    last_id_q, last_id_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;

  logic               owner_req;
  logic               owner_last;
  logic               xfer;
  logic               found;
  logic [ID_W-1:0]    winner;

  // Owner mux: live request, last flag and data of the registered owner
  always_comb begin
    owner_req  = 1'b0;
    owner_last = 1'b0;
    wdata      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_W'(i)) begin
        owner_req  = req[i];
        owner_last = req_last[i];
        wdata      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    xfer = (state_q == BURST) && owner_req && !wfull;
    winc = xfer;
    for (int i = 0; i < NUM_REQ; i++) begin
      ack[i] = xfer && (grant_id_q == ID_W'(i));
    end
  end

  // Round-robin scan starting just after the last served requester
  always_comb begin
    found  = 1'b0;
    winner = last_id_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (((int'(last_id_q) + k) % NUM_REQ) == i)) begin
          found  = 1'b1;
          winner = ID_W'(i);
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_id_d  = grant_id_q;
    last_id_d   = last_id_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          grant_id_d      = winner;
          burst_cnt_d     = '0;
          state_d         = BURST;
        end
      end
      BURST: begin
        if (xfer) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
        if (!owner_req ||
            (xfer && (owner_last || (burst_cnt_q == CNT_W'(MAX_BURST - 1))))) begin
          state_d   = IDLE;
          grant_d   = '0;
          last_id_d = grant_id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_id_q  <= '0;
      last_id_q   <= ID_W'(NUM_REQ - 1);
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_id_q  <= grant_id_d;
      last_id_q   <= last_id_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q == BURST);

endmodule
